// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter that sequences one command at a time onto a
// single-port valid/ready memory bus, with a watchdog abort for stalled accesses.
module mem_rr_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  output logic              a_rsp_err,
  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  output logic              b_rsp_err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_b;
  logic             owner_b;
  logic             grant_a, grant_b;
  logic             timeout_hit;
  logic             accept;

  // last_b=1 means B was served last, so A has priority on a tie
  assign grant_a     = a_valid & (~b_valid | last_b);
  assign grant_b     = b_valid & (~a_valid | ~last_b);
  assign a_ready     = rst & (state == IDLE) & grant_a;
  assign b_ready     = rst & (state == IDLE) & grant_b;
  assign accept      = a_ready | b_ready;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign mem_valid   = (state == ISSUE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (mem_ready || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      owner_b     <= 1'b0;
      last_b      <= 1'b1;
      cnt         <= '0;
      a_rsp_valid <= 1'b0;
      a_rsp_err   <= 1'b0;
      a_rsp_rdata <= '0;
      b_rsp_valid <= 1'b0;
      b_rsp_err   <= 1'b0;
      b_rsp_rdata <= '0;
    end else begin
      // response strobes are single-cycle; only the ISSUE exit raises them
      a_rsp_valid <= 1'b0;
      a_rsp_err   <= 1'b0;
      b_rsp_valid <= 1'b0;
      b_rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            mem_we    <= grant_a ? a_we    : b_we;
            mem_addr  <= grant_a ? a_addr  : b_addr;
            mem_wdata <= grant_a ? a_wdata : b_wdata;
            owner_b   <= ~grant_a;
            last_b    <= ~grant_a;
          end
        end
        ISSUE: begin
          cnt <= cnt + CNT_W'(1);
          if (mem_ready || timeout_hit) begin
            if (owner_b) begin
              b_rsp_valid <= 1'b1;
              b_rsp_err   <= ~mem_ready;
              b_rsp_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
            end else begin
              a_rsp_valid <= 1'b1;
              a_rsp_err   <= ~mem_ready;
              a_rsp_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed and random transactions checked against a
// transaction-level round-robin/memory model.
module tb_mem_rr_arbiter;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              a_valid, a_we, a_ready, a_rsp_valid, a_rsp_err;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rsp_rdata;
  logic              b_valid, b_we, b_ready, b_rsp_valid, b_rsp_err;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rsp_rdata;
  logic              mem_valid, mem_we, mem_ready, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  mem_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ready(a_ready),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata), .a_rsp_err(a_rsp_err),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ready(b_ready),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata), .b_rsp_err(b_rsp_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] mem_model [0:(1<<ADDR_W)-1];
  bit last_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One arbitration + memory access; delay<0 means memory never acknowledges.
  // Called just after a negedge with the DUT in IDLE; returns one negedge into the next IDLE.
  task automatic txn(input bit va, input bit vb, input bit wa, input bit wb,
                     input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ab,
                     input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db,
                     input int delay);
    bit win_a, acked, we;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] wd, exp_rd;
    a_valid = va; a_we = wa; a_addr = aa; a_wdata = da;
    b_valid = vb; b_we = wb; b_addr = ab; b_wdata = db;
    #1;
    win_a = va && (!vb || last_b);
    check("a_ready_accept", a_ready, win_a);
    check("b_ready_accept", b_ready, !win_a);
    check("busy_idle", busy, 0);
    we = win_a ? wa : wb;
    ad = win_a ? aa : ab;
    wd = win_a ? da : db;
    last_b = !win_a;
    @(negedge clk);
    a_valid = va && !win_a;
    b_valid = vb && win_a;
    a_addr = ADDR_W'($urandom); a_wdata = DATA_W'($urandom); a_we = 1'($urandom);
    b_addr = ADDR_W'($urandom); b_wdata = DATA_W'($urandom); b_we = 1'($urandom);
    acked = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      check("mem_valid_issue", mem_valid, 1);
      check("mem_we", mem_we, we);
      check("mem_addr", mem_addr, ad);
      check("mem_wdata", mem_wdata, wd);
      check("ready_issue", {a_ready, b_ready}, 0);
      check("busy_issue", busy, 1);
      mem_ready = (i == delay);
      mem_rdata = mem_ready ? mem_model[ad] : DATA_W'($urandom);
      @(negedge clk);
      if (i == delay) begin
        acked = 1;
        break;
      end
    end
    exp_rd = (acked && !we) ? mem_model[ad] : '0;
    if (acked && we) mem_model[ad] = wd;
    mem_ready = 1'($urandom);
    mem_rdata = DATA_W'($urandom);
    check("mem_valid_resp", mem_valid, 0);
    check("ready_resp", {a_ready, b_ready}, 0);
    check("a_rsp_valid", a_rsp_valid, win_a);
    check("b_rsp_valid", b_rsp_valid, !win_a);
    check("a_rsp_err", a_rsp_err, win_a && !acked);
    check("b_rsp_err", b_rsp_err, !win_a && !acked);
    check("rsp_rdata", win_a ? a_rsp_rdata : b_rsp_rdata, exp_rd);
    @(negedge clk);
    mem_ready = 0;
    check("rsp_valid_clear", {a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err}, 0);
    check("rsp_rdata_hold", win_a ? a_rsp_rdata : b_rsp_rdata, exp_rd);
    check("busy_back_idle", busy, 0);
  endtask

  initial begin
    bit [1:0] r;
    int d;
    for (int i = 0; i < (1 << ADDR_W); i++) mem_model[i] = DATA_W'($urandom);
    mem_model[8'h22] = 16'h1234;
    rst = 0; mem_ready = 0; mem_rdata = '0;
    a_valid = 1; a_we = 0; a_addr = '0; a_wdata = '0;
    b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", {a_ready, b_ready}, 0);
    check("rst_mem", {mem_valid, mem_we, mem_addr, mem_wdata}, 0);
    check("rst_rsp", {a_rsp_valid, a_rsp_err, b_rsp_valid, b_rsp_err}, 0);
    check("rst_rdata", {a_rsp_rdata, b_rsp_rdata}, 0);
    check("rst_busy", busy, 0);
    a_valid = 0;
    rst = 1;
    last_b = 1;

    txn(1, 0, 1, 0, 8'h10, 8'h00, 16'hBEEF, 16'h0000, 0);
    txn(0, 1, 0, 0, 8'h00, 8'h22, 16'h0000, 16'h0000, 3);
    for (int k = 0; k < 4; k++)
      txn(1, 1, k[0], ~k[0], ADDR_W'(8'h30 + k), ADDR_W'(8'h40 + k), 16'hA000, 16'hB000, k);
    txn(1, 0, 0, 0, 8'h55, 8'h00, 16'h0000, 16'h0000, -1);
    txn(1, 0, 0, 0, 8'h22, 8'h00, 16'h0000, 16'h0000, 1);

    // abort a B write mid-ISSUE with reset
    a_valid = 0; b_valid = 1; b_we = 1; b_addr = 8'h66; b_wdata = 16'hCAFE;
    #1;
    check("mid_b_ready", b_ready, 1);
    @(negedge clk);
    b_valid = 0;
    check("mid_mem_valid", mem_valid, 1);
    #2 rst = 0;
    #1;
    check("mid_mem_valid_drop", mem_valid, 0);
    check("mid_busy_drop", busy, 0);
    check("mid_no_rsp", b_rsp_valid, 0);
    @(negedge clk); @(negedge clk);
    check("mid_no_rsp_later", {a_rsp_valid, b_rsp_valid}, 0);
    rst = 1;
    last_b = 1;
    txn(1, 1, 0, 1, 8'h70, 8'h71, 16'h1111, 16'h2222, 0);
    txn(0, 1, 1, 1, 8'h00, 8'h80, 16'h0000, 16'h3333, 2);
    txn(0, 1, 0, 0, 8'h00, 8'h80, 16'h0000, 16'h0000, 0);

    for (int n = 0; n < 24; n++) begin
      r = 2'($urandom_range(1, 3));
      d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
      txn(r[0], r[1], 1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 15)),
          ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom), DATA_W'($urandom), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
